// File: rtl/gpu_pipe_pkg.sv
// Shared GPU pipeline constants: warp count, decoded-packet width and the
// packet field layout that the scoreboard already decodes.
package gpu_pipe_pkg;

    localparam int GPU_NUM_WARP     = 8;
    localparam int GPU_NUM_WARP_LOG = 3;
    localparam int GPU_PKT_W        = 128;

    localparam int PKT_PRED_LSB  = 0;
    localparam int PKT_PRED_W    = 4;
    localparam int PKT_REG_W     = 6;
    localparam int PKT_SRC0_LSB  = 4;
    localparam int PKT_SRC1_LSB  = 10;
    localparam int PKT_SRC2_LSB  = 16;
    localparam int PKT_DEST_LSB  = 22;
    localparam int PKT_DEST_WEN  = 28;

    typedef struct packed {
        logic [PKT_PRED_W-1:0] pred;
        logic [PKT_REG_W-1:0]  src0;
        logic [PKT_REG_W-1:0]  src1;
        logic [PKT_REG_W-1:0]  src2;
        logic [PKT_REG_W-1:0]  dest;
        logic                  dest_wen;
    } pkt_regs_t;

    function automatic pkt_regs_t pkt_regs(input logic [GPU_PKT_W-1:0] pkt);
        pkt_regs_t r;
        r.pred     = pkt[PKT_PRED_LSB +: PKT_PRED_W];
        r.src0     = pkt[PKT_SRC0_LSB +: PKT_REG_W];
        r.src1     = pkt[PKT_SRC1_LSB +: PKT_REG_W];
        r.src2     = pkt[PKT_SRC2_LSB +: PKT_REG_W];
        r.dest     = pkt[PKT_DEST_LSB +: PKT_REG_W];
        r.dest_wen = pkt[PKT_DEST_WEN];
        return r;
    endfunction

endpackage

// File: rtl/warp_issue_select_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after base_i,
// scanning upward with wrap. With no request the index reports base_i.
module rr_arbiter #(
    parameter int N    = 8,
    parameter int LOGN = 3
) (
    input  logic [N-1:0]    req_i,
    input  logic [LOGN-1:0] base_i,
    output logic [N-1:0]    grant_o,
    output logic [LOGN-1:0] idx_o,
    output logic            any_o
);

    logic [N-1:0]    req_rot;
    logic [LOGN-1:0] off;
    logic            found;

    // Rotate so that bit 0 is the base position; priority then becomes a plain LSB-first scan.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [LOGN-1:0] src;
        assign src         = base_i + LOGN'(gi);
        assign req_rot[gi] = req_i[src];
    end

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                off   = LOGN'(i);
            end
        end
        idx_o   = base_i + off;
        grant_o = '0;
        if (found) begin
            grant_o[idx_o] = 1'b1;
        end
        any_o = found;
    end

endmodule

// File: rtl/warp_issue_select.sv
// Per-warp instruction buffer with round-robin candidate selection towards the
// scoreboard and a registered issue port to operand collect.
module warp_issue_select
    import gpu_pipe_pkg::*;
#(
    parameter int NUM_WARP     = GPU_NUM_WARP,
    parameter int NUM_WARP_LOG = GPU_NUM_WARP_LOG,
    parameter int PKT_W        = GPU_PKT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_i,
    input  logic                    dec_valid_i,
    input  logic [NUM_WARP_LOG-1:0] dec_warp_i,
    input  logic [PKT_W-1:0]        dec_packet_i,
    output logic [NUM_WARP-1:0]     ibuf_free_o,
    input  logic                    flush_i,
    input  logic [NUM_WARP_LOG-1:0] flush_warp_i,
    output logic                    sel_valid_o,
    output logic [NUM_WARP_LOG-1:0] sel_warp_o,
    output logic [PKT_W-1:0]        sel_packet_o,
    input  logic                    sel_ready_i,
    output logic                    issue_valid_o,
    output logic [NUM_WARP_LOG-1:0] issue_warp_o,
    output logic [PKT_W-1:0]        issue_packet_o
);

    logic [NUM_WARP-1:0]     valid_q;
    logic [NUM_WARP-1:0]     valid_d;
    logic [PKT_W-1:0]        pkt_q [NUM_WARP];
    logic [NUM_WARP_LOG-1:0] rr_ptr_q;
    logic [NUM_WARP_LOG-1:0] rr_ptr_d;
    logic                    issue_valid_q;
    logic [NUM_WARP_LOG-1:0] issue_warp_q;
    logic [PKT_W-1:0]        issue_packet_q;

    logic [NUM_WARP-1:0]     grant;
    logic [NUM_WARP_LOG-1:0] sel_idx;
    logic                    sel_any;
    logic                    flush_hits_sel;
    logic                    fire;
    logic                    dec_wr;

    rr_arbiter #(
        .N    (NUM_WARP),
        .LOGN (NUM_WARP_LOG)
    ) u_arb (
        .req_i   (valid_q),
        .base_i  (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (sel_idx),
        .any_o   (sel_any)
    );

    assign ibuf_free_o  = ~valid_q;
    assign sel_valid_o  = sel_any;
    assign sel_warp_o   = sel_idx;
    assign sel_packet_o = sel_any ? pkt_q[sel_idx] : '0;

    // A redirect of the candidate warp kills its issue even if the scoreboard accepted it.
    assign flush_hits_sel = flush_i && (flush_warp_i == sel_idx);
    assign fire           = sel_any && sel_ready_i && !stall_i && !flush_hits_sel;
    assign dec_wr         = dec_valid_i && !stall_i && !valid_q[dec_warp_i];

    // Write beats flush so a redirect can land its first new-path packet in the same cycle.
    for (genvar gi = 0; gi < NUM_WARP; gi++) begin : g_entry
        logic wr_hit;
        logic clr_hit;
        assign wr_hit  = dec_wr && (dec_warp_i == NUM_WARP_LOG'(gi));
        assign clr_hit = !stall_i && ((fire && grant[gi])
                       || (flush_i && (flush_warp_i == NUM_WARP_LOG'(gi))));
        assign valid_d[gi] = wr_hit | (valid_q[gi] & ~clr_hit);
    end

    // Pointer advances past every presented candidate, so a blocked warp yields one round.
    assign rr_ptr_d = (sel_any && !stall_i) ? sel_idx + NUM_WARP_LOG'(1) : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (dec_wr) begin
            pkt_q[dec_warp_i] <= dec_packet_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q        <= '0;
            rr_ptr_q       <= '0;
            issue_valid_q  <= 1'b0;
            issue_warp_q   <= '0;
            issue_packet_q <= '0;
        end else begin
            valid_q       <= valid_d;
            rr_ptr_q      <= rr_ptr_d;
            issue_valid_q <= fire;
            if (fire) begin
                issue_warp_q   <= sel_idx;
                issue_packet_q <= sel_packet_o;
            end
        end
    end

    assign issue_valid_o  = issue_valid_q;
    assign issue_warp_o   = issue_warp_q;
    assign issue_packet_o = issue_packet_q;

    // Decode must only target free entries; an overwrite would silently lose a packet.
    a_no_overwrite: assert property (@(posedge clk) disable iff (reset)
        (dec_valid_i && !stall_i) |-> !valid_q[dec_warp_i])
        else $error("decode write to occupied warp entry %0d", dec_warp_i);

endmodule

// File: tb/tb_warp_issue_select.sv
// Bench for warp_issue_select: directed scenarios plus random traffic, all
// checked against a per-warp queue model of the buffer and issue rules.
module tb_warp_issue_select;

    localparam int NW  = 8;
    localparam int NWL = 3;
    localparam int PW  = 128;

    logic           clk = 1'b0;
    logic           reset;
    logic           stall_i;
    logic           dec_valid_i;
    logic [NWL-1:0] dec_warp_i;
    logic [PW-1:0]  dec_packet_i;
    logic [NW-1:0]  ibuf_free_o;
    logic           flush_i;
    logic [NWL-1:0] flush_warp_i;
    logic           sel_valid_o;
    logic [NWL-1:0] sel_warp_o;
    logic [PW-1:0]  sel_packet_o;
    logic           sel_ready_i;
    logic           issue_valid_o;
    logic [NWL-1:0] issue_warp_o;
    logic [PW-1:0]  issue_packet_o;

    warp_issue_select dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall_i),
        .dec_valid_i    (dec_valid_i),
        .dec_warp_i     (dec_warp_i),
        .dec_packet_i   (dec_packet_i),
        .ibuf_free_o    (ibuf_free_o),
        .flush_i        (flush_i),
        .flush_warp_i   (flush_warp_i),
        .sel_valid_o    (sel_valid_o),
        .sel_warp_o     (sel_warp_o),
        .sel_packet_o   (sel_packet_o),
        .sel_ready_i    (sel_ready_i),
        .issue_valid_o  (issue_valid_o),
        .issue_warp_o   (issue_warp_o),
        .issue_packet_o (issue_packet_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: buffer contents, scan start, and expected issue register.
    bit             m_valid [NW];
    logic [PW-1:0]  m_pkt   [NW];
    int             m_ptr = 0;
    bit             exp_iv = 1'b0;
    logic [NWL-1:0] exp_iw = '0;
    logic [PW-1:0]  exp_ip = '0;

    function automatic int m_cand();
        for (int k = 0; k < NW; k++) begin
            int w;
            w = (m_ptr + k) % NW;
            if (m_valid[w]) return w;
        end
        return -1;
    endfunction

    function automatic logic [NWL-1:0] exp_sel_warp();
        int c;
        c = m_cand();
        return (c >= 0) ? NWL'(c) : NWL'(m_ptr);
    endfunction

    function automatic logic [PW-1:0] exp_sel_pkt();
        int c;
        c = m_cand();
        return (c >= 0) ? m_pkt[c] : '0;
    endfunction

    function automatic logic [NW-1:0] m_free();
        logic [NW-1:0] f;
        for (int k = 0; k < NW; k++) f[k] = !m_valid[k];
        return f;
    endfunction

    function automatic logic [PW-1:0] rnd_pkt();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clock();
        int c;
        bit fire;
        bit wr_ok;
        if (reset) begin
            for (int k = 0; k < NW; k++) m_valid[k] = 1'b0;
            m_ptr  = 0;
            exp_iv = 1'b0;
            exp_iw = '0;
            exp_ip = '0;
            return;
        end
        exp_iv = 1'b0;
        if (stall_i) return;
        c     = m_cand();
        wr_ok = dec_valid_i && !m_valid[dec_warp_i];
        fire  = (c >= 0) && sel_ready_i && !(flush_i && int'(flush_warp_i) == c);
        if (fire) begin
            exp_iv     = 1'b1;
            exp_iw     = NWL'(c);
            exp_ip     = m_pkt[c];
            m_valid[c] = 1'b0;
        end
        if (c >= 0) m_ptr = (c + 1) % NW;
        if (flush_i) m_valid[flush_warp_i] = 1'b0;
        if (wr_ok) begin
            m_valid[dec_warp_i] = 1'b1;
            m_pkt[dec_warp_i]   = dec_packet_i;
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        reset        = 1'b0;
        stall_i      = 1'b0;
        dec_valid_i  = 1'b0;
        dec_warp_i   = '0;
        dec_packet_i = '0;
        flush_i      = 1'b0;
        flush_warp_i = '0;
        sel_ready_i  = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            n_checks++;
            if (ibuf_free_o !== 8'hFF || sel_valid_o !== 1'b0 || sel_warp_o !== 3'd0) begin
                n_errors++;
                $display("FAIL reset_idle_sel cyc=%0d: got free=%h v=%0b w=%0d, required free=ff v=0 w=0",
                         cyc, ibuf_free_o, sel_valid_o, sel_warp_o);
            end
            tick();
            n_checks++;
            if (issue_valid_o !== 1'b0 || issue_warp_o !== 3'd0 || issue_packet_o !== '0) begin
                n_errors++;
                $display("FAIL reset_idle_issue cyc=%0d: got iv=%0b iw=%0d ip=%h, required 0/0/0",
                         cyc, issue_valid_o, issue_warp_o, issue_packet_o);
            end
        end
    endtask

    task automatic test_two_warps();
        logic [PW-1:0] pa;
        logic [PW-1:0] pb;
        pa = rnd_pkt();
        pb = rnd_pkt();
        set_idle();
        sel_ready_i = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            dec_valid_i  = (cyc < 2);
            dec_warp_i   = (cyc == 0) ? 3'd2 : 3'd5;
            dec_packet_i = (cyc == 0) ? pa : pb;
            #1;
            n_checks++;
            if (sel_valid_o !== (m_cand() >= 0) || sel_warp_o !== exp_sel_warp()
                || sel_packet_o !== exp_sel_pkt() || ibuf_free_o !== m_free()) begin
                n_errors++;
                $display("FAIL two_warps_sel cyc=%0d: got v=%0b w=%0d free=%h, required v=%0b w=%0d free=%h",
                         cyc, sel_valid_o, sel_warp_o, ibuf_free_o, m_cand() >= 0, exp_sel_warp(), m_free());
            end
            tick();
            n_checks++;
            if (issue_valid_o !== exp_iv || issue_warp_o !== exp_iw || issue_packet_o !== exp_ip) begin
                n_errors++;
                $display("FAIL two_warps_issue cyc=%0d: got iv=%0b iw=%0d, required iv=%0b iw=%0d",
                         cyc, issue_valid_o, issue_warp_o, exp_iv, exp_iw);
            end
            if (cyc == 1 || cyc == 2) begin
                n_checks++;
                if (issue_valid_o !== 1'b1 || issue_warp_o !== ((cyc == 1) ? 3'd2 : 3'd5)
                    || issue_packet_o !== ((cyc == 1) ? pa : pb)) begin
                    n_errors++;
                    $display("FAIL two_warps_order cyc=%0d: got iv=%0b iw=%0d, required iv=1 iw=%0d",
                             cyc, issue_valid_o, issue_warp_o, (cyc == 1) ? 2 : 5);
                end
            end
        end
        n_checks++;
        if (ibuf_free_o !== 8'hFF) begin
            n_errors++;
            $display("FAIL two_warps_free: got %h, required ff", ibuf_free_o);
        end
    endtask

    task automatic test_rotation();
        int issues [NW];
        int first0;
        for (int k = 0; k < NW; k++) issues[k] = 0;
        first0 = -1;
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            dec_valid_i  = (cyc < 3);
            dec_warp_i   = NWL'(cyc);
            dec_packet_i = rnd_pkt();
            if (cyc < 3)       sel_ready_i = 1'b0;
            else if (cyc < 10) sel_ready_i = (m_cand() != 0);
            else               sel_ready_i = 1'b1;
            #1;
            n_checks++;
            if (sel_valid_o !== (m_cand() >= 0) || sel_warp_o !== exp_sel_warp()
                || sel_packet_o !== exp_sel_pkt() || ibuf_free_o !== m_free()) begin
                n_errors++;
                $display("FAIL rotation_sel cyc=%0d: got v=%0b w=%0d free=%h, required v=%0b w=%0d free=%h",
                         cyc, sel_valid_o, sel_warp_o, ibuf_free_o, m_cand() >= 0, exp_sel_warp(), m_free());
            end
            tick();
            n_checks++;
            if (issue_valid_o !== exp_iv || issue_warp_o !== exp_iw || issue_packet_o !== exp_ip) begin
                n_errors++;
                $display("FAIL rotation_issue cyc=%0d: got iv=%0b iw=%0d, required iv=%0b iw=%0d",
                         cyc, issue_valid_o, issue_warp_o, exp_iv, exp_iw);
            end
            if (issue_valid_o === 1'b1) begin
                issues[issue_warp_o]++;
                if (issue_warp_o == 3'd0 && first0 < 0) first0 = cyc;
            end
        end
        n_checks++;
        if (issues[0] != 1 || issues[1] != 1 || issues[2] != 1 || first0 != 10) begin
            n_errors++;
            $display("FAIL rotation_counts: got w0=%0d w1=%0d w2=%0d first0=%0d, required 1 1 1 first0=10",
                     issues[0], issues[1], issues[2], first0);
        end
    endtask

    task automatic test_flush();
        logic [PW-1:0] pa;
        logic [PW-1:0] pb;
        pa = rnd_pkt();
        pb = rnd_pkt();
        set_idle();
        for (int cyc = 0; cyc < 5; cyc++) begin
            dec_valid_i  = (cyc == 0 || cyc == 2);
            dec_warp_i   = 3'd3;
            dec_packet_i = (cyc == 0) ? pa : pb;
            flush_i      = (cyc == 1 || cyc == 2);
            flush_warp_i = 3'd3;
            sel_ready_i  = (cyc == 1 || cyc == 3);
            #1;
            n_checks++;
            if (sel_valid_o !== (m_cand() >= 0) || sel_warp_o !== exp_sel_warp()
                || sel_packet_o !== exp_sel_pkt() || ibuf_free_o !== m_free()) begin
                n_errors++;
                $display("FAIL flush_sel cyc=%0d: got v=%0b w=%0d free=%h, required v=%0b w=%0d free=%h",
                         cyc, sel_valid_o, sel_warp_o, ibuf_free_o, m_cand() >= 0, exp_sel_warp(), m_free());
            end
            if (cyc == 3) begin
                n_checks++;
                if (sel_warp_o !== 3'd3 || sel_packet_o !== pb || ibuf_free_o[3] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL flush_rewrite: got w=%0d free3=%0b pkt=%h, required w=3 free3=0 pkt=%h",
                             sel_warp_o, ibuf_free_o[3], sel_packet_o, pb);
                end
            end
            tick();
            n_checks++;
            if (issue_valid_o !== exp_iv || issue_warp_o !== exp_iw || issue_packet_o !== exp_ip) begin
                n_errors++;
                $display("FAIL flush_issue cyc=%0d: got iv=%0b iw=%0d, required iv=%0b iw=%0d",
                         cyc, issue_valid_o, issue_warp_o, exp_iv, exp_iw);
            end
            if (cyc == 1) begin
                n_checks++;
                if (issue_valid_o !== 1'b0 || ibuf_free_o[3] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL flush_kill: got iv=%0b free3=%0b, required iv=0 free3=1",
                             issue_valid_o, ibuf_free_o[3]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [PW-1:0] pa;
        pa = rnd_pkt();
        set_idle();
        for (int cyc = 0; cyc < 6; cyc++) begin
            stall_i      = (cyc >= 1 && cyc <= 3);
            dec_valid_i  = (cyc <= 3);
            dec_warp_i   = (cyc == 0) ? 3'd1 : 3'd4;
            dec_packet_i = (cyc == 0) ? pa : rnd_pkt();
            flush_i      = stall_i;
            flush_warp_i = 3'd1;
            sel_ready_i  = (cyc >= 1);
            #1;
            n_checks++;
            if (sel_valid_o !== (m_cand() >= 0) || sel_warp_o !== exp_sel_warp()
                || sel_packet_o !== exp_sel_pkt() || ibuf_free_o !== m_free()) begin
                n_errors++;
                $display("FAIL stall_sel cyc=%0d: got v=%0b w=%0d free=%h, required v=%0b w=%0d free=%h",
                         cyc, sel_valid_o, sel_warp_o, ibuf_free_o, m_cand() >= 0, exp_sel_warp(), m_free());
            end
            if (cyc >= 1 && cyc <= 4) begin
                n_checks++;
                if (sel_valid_o !== 1'b1 || sel_warp_o !== 3'd1 || ibuf_free_o[4] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL stall_frozen cyc=%0d: got v=%0b w=%0d free4=%0b, required v=1 w=1 free4=1",
                             cyc, sel_valid_o, sel_warp_o, ibuf_free_o[4]);
                end
            end
            if (cyc == 5) begin
                n_checks++;
                if (sel_valid_o !== 1'b0 || sel_warp_o !== 3'd2) begin
                    n_errors++;
                    $display("FAIL stall_ptr: got v=%0b w=%0d, required v=0 w=2", sel_valid_o, sel_warp_o);
                end
            end
            tick();
            n_checks++;
            if (issue_valid_o !== exp_iv || issue_warp_o !== exp_iw || issue_packet_o !== exp_ip) begin
                n_errors++;
                $display("FAIL stall_issue cyc=%0d: got iv=%0b iw=%0d, required iv=%0b iw=%0d",
                         cyc, issue_valid_o, issue_warp_o, exp_iv, exp_iw);
            end
            if (cyc >= 1 && cyc <= 4) begin
                n_checks++;
                if (issue_valid_o !== (cyc == 4) || (cyc == 4 && (issue_warp_o !== 3'd1 || issue_packet_o !== pa))) begin
                    n_errors++;
                    $display("FAIL stall_release cyc=%0d: got iv=%0b iw=%0d, required iv=%0b iw=1",
                             cyc, issue_valid_o, issue_warp_o, cyc == 4);
                end
            end
        end
    endtask

    task automatic test_wrap();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            dec_valid_i  = (cyc <= 2);
            dec_warp_i   = (cyc == 0) ? 3'd7 : ((cyc == 1) ? 3'd6 : 3'd0);
            dec_packet_i = rnd_pkt();
            sel_ready_i  = (cyc >= 2);
            #1;
            n_checks++;
            if (sel_valid_o !== (m_cand() >= 0) || sel_warp_o !== exp_sel_warp()
                || sel_packet_o !== exp_sel_pkt() || ibuf_free_o !== m_free()) begin
                n_errors++;
                $display("FAIL wrap_sel cyc=%0d: got v=%0b w=%0d free=%h, required v=%0b w=%0d free=%h",
                         cyc, sel_valid_o, sel_warp_o, ibuf_free_o, m_cand() >= 0, exp_sel_warp(), m_free());
            end
            if (cyc == 3 || cyc == 5) begin
                n_checks++;
                if (sel_valid_o !== (cyc == 3) || sel_warp_o !== ((cyc == 3) ? 3'd7 : 3'd1)) begin
                    n_errors++;
                    $display("FAIL wrap_ptr cyc=%0d: got v=%0b w=%0d, required v=%0b w=%0d",
                             cyc, sel_valid_o, sel_warp_o, cyc == 3, (cyc == 3) ? 7 : 1);
                end
            end
            tick();
            n_checks++;
            if (issue_valid_o !== exp_iv || issue_warp_o !== exp_iw || issue_packet_o !== exp_ip) begin
                n_errors++;
                $display("FAIL wrap_issue cyc=%0d: got iv=%0b iw=%0d, required iv=%0b iw=%0d",
                         cyc, issue_valid_o, issue_warp_o, exp_iv, exp_iw);
            end
            if (cyc == 3 || cyc == 4) begin
                n_checks++;
                if (issue_valid_o !== 1'b1 || issue_warp_o !== ((cyc == 3) ? 3'd7 : 3'd0)) begin
                    n_errors++;
                    $display("FAIL wrap_order cyc=%0d: got iv=%0b iw=%0d, required iv=1 iw=%0d",
                             cyc, issue_valid_o, issue_warp_o, (cyc == 3) ? 7 : 0);
                end
            end
        end
    endtask

    task automatic test_random();
        int w;
        int c;
        set_idle();
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset       = ($urandom_range(0, 99) == 0);
            stall_i     = ($urandom_range(0, 9) == 0);
            sel_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 5) == 0);
            c           = m_cand();
            flush_warp_i = (c >= 0 && $urandom_range(0, 1) == 1) ? NWL'(c) : NWL'($urandom_range(0, NW - 1));
            w            = $urandom_range(0, NW - 1);
            dec_warp_i   = NWL'(w);
            dec_packet_i = rnd_pkt();
            dec_valid_i  = !m_valid[w] && ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (sel_valid_o !== (m_cand() >= 0) || sel_warp_o !== exp_sel_warp()
                || sel_packet_o !== exp_sel_pkt() || ibuf_free_o !== m_free()) begin
                n_errors++;
                $display("FAIL random_sel cyc=%0d: got v=%0b w=%0d free=%h, required v=%0b w=%0d free=%h",
                         cyc, sel_valid_o, sel_warp_o, ibuf_free_o, m_cand() >= 0, exp_sel_warp(), m_free());
            end
            tick();
            n_checks++;
            if (issue_valid_o !== exp_iv || issue_warp_o !== exp_iw || issue_packet_o !== exp_ip) begin
                n_errors++;
                $display("FAIL random_issue cyc=%0d: got iv=%0b iw=%0d ip=%h, required iv=%0b iw=%0d ip=%h",
                         cyc, issue_valid_o, issue_warp_o, issue_packet_o, exp_iv, exp_iw, exp_ip);
            end
        end
        set_idle();
    endtask

    initial begin
        for (int k = 0; k < NW; k++) m_valid[k] = 1'b0;
        set_idle();
        test_reset();
        test_two_warps();
        test_rotation();
        test_flush();
        test_stall();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/warp_issue_select.md
# warp_issue_select

Per-warp instruction buffer and round-robin issue selector that sits directly upstream of the register scoreboard. It holds one decoded instruction packet per warp and each cycle presents one candidate warp/packet to the scoreboard. On the scoreboard's same-cycle ready it issues the packet to the operand-collect/execute stage through a registered output, rotating priority so that a warp blocked by a hazard cannot starve the others.

## Interface
Parameters:
- NUM_WARP, 8, number of hardware warps (power of two)
- NUM_WARP_LOG, 3, log2(NUM_WARP)
- PKT_W, 128, decoded packet width (matches scoreboard toSelect packet)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- stall_i  in  1  pipeline stall; freezes all state and outputs
- dec_valid_i  in  1  decode writes a packet this cycle
- dec_warp_i  in  NUM_WARP_LOG  target warp of the write
- dec_packet_i  in  PKT_W  decoded packet
- ibuf_free_o  out  NUM_WARP  per-warp entry empty (decode may write)
- flush_i  in  1  discard buffered packet of flush_warp_i (branch redirect)
- flush_warp_i  in  NUM_WARP_LOG  warp to flush
- sel_valid_o  out  1  candidate presented to scoreboard
- sel_warp_o  out  NUM_WARP_LOG  candidate warp
- sel_packet_o  out  PKT_W  candidate packet
- sel_ready_i  in  1  scoreboard: candidate hazard-free (same cycle)
- issue_valid_o  out  1  registered issue strobe
- issue_warp_o  out  NUM_WARP_LOG  issued warp
- issue_packet_o  out  PKT_W  issued packet

## Operation
- State: valid[NUM_WARP], pkt[NUM_WARP][PKT_W], rr_ptr (NUM_WARP_LOG bits), issue output register.
- ibuf_free_o[w] = ~valid[w]. Decode writes only to free entries. A write to a valid entry is a protocol error: the write is dropped and flagged by a simulation assertion.
- Candidate: first w with valid[w]=1, scanning rr_ptr, rr_ptr+1, … mod NUM_WARP. sel_valid_o = |valid. When sel_valid_o=0, sel_warp_o = rr_ptr and sel_packet_o = 0.
- Issue fire = sel_valid_o & sel_ready_i & ~stall_i & ~(flush_i & flush_warp_i==sel_warp_o).
- On fire:
  - valid[sel] cleared.
  - Next cycle: issue_valid_o=1, issue_warp_o=sel, issue_packet_o=pkt[sel].
- On any cycle with sel_valid_o=1 and ~stall_i: rr_ptr ← sel_warp_o+1 (wraps NUM_WARP-1→0), whether or not the candidate fired. A blocked warp therefore yields for one round.
- Without fire, or during stall: issue_valid_o=0 next cycle. issue_warp_o and issue_packet_o hold their last values.
- Flush: valid[flush_warp_i] cleared. Flush overrides issue of the same warp.
- Simultaneous flush and write to the same warp: the write wins (valid=1, new packet). Models redirect followed by the first new-path instruction.
- stall_i=1: no writes, flushes, rr_ptr moves or issues take effect. sel_* stay combinationally driven from the frozen state.

## Timing
- Reset values: valid=0, rr_ptr=0, issue_valid_o=0, issue_warp_o=0, issue_packet_o=0. Therefore ibuf_free_o=all-ones and sel_valid_o=0.
- Reset mid-operation discards all buffered packets; no issue in the cycle after reset.
- Decode write at edge N makes the entry visible as a candidate in cycle N+1 and clears ibuf_free_o[w] in cycle N+1.
- sel_* → sel_ready_i → fire is a combinational path within one cycle. issue_* is registered: latency of 1 cycle from fire.
- An issued entry is free in the cycle after fire. Decode can refill it then, so there is 1 issue per warp every 2 cycles at best.
- Throughput: 1 issue/cycle across warps.

## Structure
- Shared package (gpu_pipe_pkg): NUM_WARP, NUM_WARP_LOG, packet width, and the packet field offsets already used by the scoreboard (pred/src/dest fields).
- Sub-module rr_arbiter: NUM_WARP-wide request vector plus base pointer in; one-hot grant and encoded index out; purely combinational.
- This block instantiates rr_arbiter, the entry array and the issue register.

## Test plan
- Reset then idle: ibuf_free_o=8'hFF, sel_valid_o=0, issue_valid_o=0 for 10 cycles.
- Write warps 2 and 5, ready held 1 → issues warp 2 then warp 5 on consecutive cycles, packets match, ibuf_free_o returns to 8'hFF.
- Warps 0,1,2 valid, ready=0 whenever sel_warp_o=0 → candidates rotate 0,1(issued),2(issued),0; warp 0 issues once ready rises.
- flush_i for warp 3 in the cycle warp 3 is the candidate with ready=1 → no issue, valid[3]=0. Same-cycle flush+write of warp 3 → warp 3 valid with the new packet.
- stall_i=1 for 3 cycles with warp 1 valid and ready=1 → no issue, rr_ptr unchanged; warp 1 issues the cycle after stall drops.
- Wrap: rr_ptr=7, warps 7 and 0 valid → issue 7 then 0, rr_ptr=1.
